// File: rtl/logic_arbiter_pkg.sv
// rtl/logic_arbiter_pkg.sv - shared opcode encodings for the bitwise logic datapath
package logic_arbiter_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_AND = 2'b00;
   localparam op_t OP_OR  = 2'b01;
   localparam op_t OP_XOR = 2'b10;
   localparam op_t OP_NOR = 2'b11;

endpackage

// File: rtl/logic_arbiter_logic32.sv
// rtl/logic_arbiter_logic32.sv - combinational bitwise logic unit shared by both requesters
module logic32
   import logic_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_t              op,
   output logic [WIDTH-1:0] res
);

   // decode the opcode into one of four bitwise functions
   always_comb begin
      res = '0;
      case (op)
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_NOR:  res = ~(a | b);
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/logic_arbiter.sv
// rtl/logic_arbiter.sv - round-robin arbiter feeding two requesters into one registered logic unit
module logic_arbiter
   import logic_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_id,
   input  logic             res_ready
);

   // prio=1 means requester 1 wins the next contested cycle
   logic             prio;
   logic             slot_free;
   logic             grant0;
   logic             grant1;
   op_t              sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [WIDTH-1:0] alu_res;

   // slot can take a new result when empty or being drained this cycle
   assign slot_free = !res_valid || res_ready;

   // grants depend only on valids, slot state and priority, never on payload
   assign grant0 = !reset && slot_free && req0_valid && (!req1_valid || !prio);
   assign grant1 = !reset && slot_free && req1_valid && (!req0_valid ||  prio);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // steer the granted requester's operands into the shared unit
   assign sel_op = grant1 ? req1_op : req0_op;
   assign sel_a  = grant1 ? req1_a  : req0_a;
   assign sel_b  = grant1 ? req1_b  : req0_b;

   logic32 #(.WIDTH(WIDTH)) u_logic32 (
      .a   (sel_a),
      .b   (sel_b),
      .op  (sel_op),
      .res (alu_res)
   );

   // result register and round-robin pointer; pointer moves only on a request transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= 1'b0;
         prio      <= 1'b0;
      end else if (grant0 || grant1) begin
         res_valid <= 1'b1;
         res_data  <= alu_res;
         res_id    <= grant1;
         prio      <= grant0;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule
